// File: rtl/nios2_mul_pkg.sv
// Shared definitions for the Nios II pipelined multiplier: op encodings,
// operand-signedness helpers and the fixed pipeline latency.
package nios2_mul_pkg;

    typedef enum logic [1:0] {
        OP_MUL    = 2'd0,
        OP_MULXSS = 2'd1,
        OP_MULXSU = 2'd2,
        OP_MULXUU = 2'd3
    } mul_op_e;

    localparam int MUL_LAT = 3;

    function automatic logic op_a_signed(input mul_op_e op);
        return (op == OP_MULXSS) || (op == OP_MULXSU);
    endfunction

    function automatic logic op_b_signed(input mul_op_e op);
        return (op == OP_MULXSS);
    endfunction

endpackage

// File: rtl/nios2_mul_pp.sv
// S1 of the multiplier: four unsigned HALFxHALF partial products registered
// together with the operands, op and tag that later stages need.
module nios2_mul_pp
    import nios2_mul_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              advance_i,
    input  logic              flush_i,
    input  logic              accept_i,
    input  mul_op_e           op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [TAG_W-1:0]  tag_i,
    output logic              valid_o,
    output mul_op_e           op_o,
    output logic [TAG_W-1:0]  tag_o,
    output logic [DATA_W-1:0] a_o,
    output logic [DATA_W-1:0] b_o,
    output logic [DATA_W-1:0] pll_o,
    output logic [DATA_W-1:0] plh_o,
    output logic [DATA_W-1:0] phl_o,
    output logic [DATA_W-1:0] phh_o
);

    localparam int HALF = DATA_W / 2;

    logic              valid_q;
    mul_op_e           op_q;
    logic [TAG_W-1:0]  tag_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic [DATA_W-1:0] pll_q, plh_q, phl_q, phh_q;
    logic [DATA_W-1:0] pll_d, plh_d, phl_d, phh_d;

    always_comb begin
        pll_d = DATA_W'(a_i[HALF-1:0])      * DATA_W'(b_i[HALF-1:0]);
        plh_d = DATA_W'(a_i[HALF-1:0])      * DATA_W'(b_i[DATA_W-1:HALF]);
        phl_d = DATA_W'(a_i[DATA_W-1:HALF]) * DATA_W'(b_i[HALF-1:0]);
        phh_d = DATA_W'(a_i[DATA_W-1:HALF]) * DATA_W'(b_i[DATA_W-1:HALF]);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            op_q    <= OP_MUL;
            tag_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            pll_q   <= '0;
            plh_q   <= '0;
            phl_q   <= '0;
            phh_q   <= '0;
        end else begin
            if (flush_i) begin
                valid_q <= 1'b0;
            end else if (advance_i) begin
                valid_q <= accept_i;
            end
            if (advance_i) begin
                op_q  <= op_i;
                tag_q <= tag_i;
                a_q   <= a_i;
                b_q   <= b_i;
                pll_q <= pll_d;
                plh_q <= plh_d;
                phl_q <= phl_d;
                phh_q <= phh_d;
            end
        end
    end

    assign valid_o = valid_q;
    assign op_o    = op_q;
    assign tag_o   = tag_q;
    assign a_o     = a_q;
    assign b_o     = b_q;
    assign pll_o   = pll_q;
    assign plh_o   = plh_q;
    assign phl_o   = phl_q;
    assign phh_o   = phh_q;

endmodule

// File: rtl/nios2_mul_pipe.sv
// Three-stage Nios II multiplier (MUL/MULXSS/MULXSU/MULXUU) with flow control,
// flush and result tag. Define NIOS2_MUL_PERF_EN to build the perf counters.
module nios2_mul_pipe
    import nios2_mul_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [TAG_W-1:0]  out_tag,
    output logic [31:0]       perf_done,
    output logic [31:0]       perf_stall
);

    // Handshake: a transfer happens on any edge where valid & ready are both 1.
    // The whole pipe advances as one unit unless S3 holds a result the sink
    // refuses; in_ready mirrors that. flush kills everything and beats accept.
    logic advance;
    logic accept;

    logic              s1_valid;
    mul_op_e           s1_op;
    logic [TAG_W-1:0]  s1_tag;
    logic [DATA_W-1:0] s1_a, s1_b;
    logic [DATA_W-1:0] s1_pll, s1_plh, s1_phl, s1_phh;

    logic              s2_valid_q;
    mul_op_e           s2_op_q;
    logic [TAG_W-1:0]  s2_tag_q;
    logic [DATA_W-1:0] s2_lo_q, s2_hi_q;
    logic [DATA_W-1:0] s2_lo_d, s2_hi_d;
    logic [2*DATA_W-1:0] mid_sum, p_full;

    logic              s3_valid_q;
    logic [TAG_W-1:0]  s3_tag_q;
    logic [DATA_W-1:0] s3_result_q, s3_result_d;

    assign advance  = ~s3_valid_q | out_ready;
    assign in_ready = advance;
    assign accept   = in_valid & advance & ~flush;

    nios2_mul_pp #(
        .DATA_W (DATA_W),
        .TAG_W  (TAG_W)
    ) u_pp (
        .clk       (clk),
        .reset_n   (reset_n),
        .advance_i (advance),
        .flush_i   (flush),
        .accept_i  (accept),
        .op_i      (mul_op_e'(in_op)),
        .a_i       (in_a),
        .b_i       (in_b),
        .tag_i     (in_tag),
        .valid_o   (s1_valid),
        .op_o      (s1_op),
        .tag_o     (s1_tag),
        .a_o       (s1_a),
        .b_o       (s1_b),
        .pll_o     (s1_pll),
        .plh_o     (s1_plh),
        .phl_o     (s1_phl),
        .phh_o     (s1_phh)
    );

    // Unsigned full product, then two's-complement fixup of the upper word.
    always_comb begin
        mid_sum = (2*DATA_W)'(s1_plh) + (2*DATA_W)'(s1_phl);
        p_full  = (2*DATA_W)'(s1_pll) + (mid_sum << (DATA_W / 2))
                + {s1_phh, {DATA_W{1'b0}}};
        s2_lo_d = p_full[DATA_W-1:0];
        s2_hi_d = p_full[2*DATA_W-1:DATA_W];
        if (op_a_signed(s1_op) && s1_a[DATA_W-1]) begin
            s2_hi_d = s2_hi_d - s1_b;
        end
        if (op_b_signed(s1_op) && s1_b[DATA_W-1]) begin
            s2_hi_d = s2_hi_d - s1_a;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s2_valid_q <= 1'b0;
            s2_op_q    <= OP_MUL;
            s2_tag_q   <= '0;
            s2_lo_q    <= '0;
            s2_hi_q    <= '0;
        end else begin
            if (flush) begin
                s2_valid_q <= 1'b0;
            end else if (advance) begin
                s2_valid_q <= s1_valid;
            end
            if (advance) begin
                s2_op_q  <= s1_op;
                s2_tag_q <= s1_tag;
                s2_lo_q  <= s2_lo_d;
                s2_hi_q  <= s2_hi_d;
            end
        end
    end

    // Bubbles load zero so out_result reads 0 whenever out_valid is low.
    always_comb begin
        s3_result_d = '0;
        if (s2_valid_q) begin
            s3_result_d = (s2_op_q == OP_MUL) ? s2_lo_q : s2_hi_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s3_valid_q  <= 1'b0;
            s3_tag_q    <= '0;
            s3_result_q <= '0;
        end else if (flush) begin
            s3_valid_q  <= 1'b0;
            s3_tag_q    <= '0;
            s3_result_q <= '0;
        end else if (advance) begin
            s3_valid_q  <= s2_valid_q;
            s3_tag_q    <= s2_tag_q;
            s3_result_q <= s3_result_d;
        end
    end

    assign out_valid  = s3_valid_q;
    assign out_tag    = s3_tag_q;
    assign out_result = s3_result_q;

`ifdef NIOS2_MUL_PERF_EN
    logic [31:0] perf_done_q, perf_stall_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            perf_done_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            if (s3_valid_q && out_ready) begin
                perf_done_q <= perf_done_q + 32'd1;
            end
            if (s3_valid_q && !out_ready) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_done  = perf_done_q;
    assign perf_stall = perf_stall_q;
`else
    assign perf_done  = '0;
    assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_nios2_mul_pipe.sv
// Bench for nios2_mul_pipe: directed corner cases plus random traffic, checked
// by a scoreboard against a sign-extended 2*DATA_W product model.
module tb_nios2_mul_pipe;
    import nios2_mul_pkg::*;

    localparam int DW = 32;
    localparam int TW = 5;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    in_op = 2'd0;
    logic [DW-1:0] in_a = '0;
    logic [DW-1:0] in_b = '0;
    logic [TW-1:0] in_tag = '0;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_result;
    logic [TW-1:0] out_tag;
    logic [31:0]   perf_done;
    logic [31:0]   perf_stall;

    nios2_mul_pipe #(.DATA_W(DW), .TAG_W(TW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .perf_done  (perf_done),
        .perf_stall (perf_stall)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation ran past its time limit");
        $fatal(1, "timeout");
    end

    // ---------------- counters and model ----------------
    int n_cmp = 0;
    int n_err = 0;

    logic [DW+TW-1:0] exp_q[$];
    int               iss_q[$];
    int               stall_m = 0;
    int               done_m  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: sign- or zero-extend each operand to 2*DW and multiply.
    function automatic logic [DW-1:0] model(input logic [1:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
        logic [2*DW-1:0] ea, eb, prod;
        logic sa, sb;
        sa = ((op == 2'd1) || (op == 2'd2)) && a[DW-1];
        sb = (op == 2'd1) && b[DW-1];
        ea = {{DW{sa}}, a};
        eb = {{DW{sb}}, b};
        prod = ea * eb;
        return (op == 2'd0) ? prod[DW-1:0] : prod[2*DW-1:DW];
    endfunction

    // ---------------- sink ready generator ----------------
    int         ready_mode = 0;
    int         pidx = 0;
    logic [3:0] ready_pat = 4'b1001;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: begin
                out_ready = ready_pat[pidx];
                pidx = (pidx + 1) % 4;
            end
            2: out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    // ---------------- monitor / scoreboard ----------------
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_res;
    logic [TW-1:0] prev_tag;

    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            iss_q.delete();
            prev_stall = 1'b0;
            stall_m    = 0;
            done_m     = 0;
        end else begin
            check("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
            if (prev_stall) begin
                check("stall_valid_held", 64'(out_valid), 64'(1));
                check("stall_result_held", 64'(out_result), 64'(prev_res));
                check("stall_tag_held", 64'(out_tag), 64'(prev_tag));
            end
            if (out_valid && out_ready) begin
                done_m++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_output: got tag %0h result %0h expected none (cycle %0d)",
                             out_tag, out_result, cyc);
                end else begin
                    logic [DW+TW-1:0] e;
                    int               iss;
                    e   = exp_q.pop_front();
                    iss = iss_q.pop_front();
                    check("result", 64'(out_result), 64'(e[DW-1:0]));
                    check("tag", 64'(out_tag), 64'(e[DW+TW-1:DW]));
                    check("latency", 64'((cyc - stall_m) - iss), 64'(MUL_LAT));
                end
            end
            if (out_valid && !out_ready) stall_m++;
            prev_stall = out_valid && !out_ready && !flush;
            prev_res   = out_result;
            prev_tag   = out_tag;
            if (flush) begin
                exp_q.delete();
                iss_q.delete();
            end else if (in_valid && in_ready) begin
                exp_q.push_back({in_tag, model(in_op, in_a, in_b)});
                iss_q.push_back(cyc - stall_m);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // All tasks start and end 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [TW-1:0] tag);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL issue_timeout: got in_ready 0 for 200 cycles expected acceptance");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        ready_mode = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) break;
        end
        check("drain_empty", 64'(exp_q.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rnd_operand();
        logic [63:0]   r;
        logic [DW-1:0] one;
        one = 1;
        r = {$urandom(), $urandom()};
        case ($urandom_range(0, 7))
            0: return '0;
            1: return '1;
            2: return one << (DW - 1);
            3: return (one << (DW - 1)) - one;
            default: return r[DW-1:0];
        endcase
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        logic [DW-1:0] ones, msb;
        ones = '1;
        msb  = '0;
        msb[DW-1] = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_out_result", 64'(out_result), 64'(0));
        check("reset_in_ready", 64'(in_ready), 64'(1));
        check("reset_perf_done", 64'(perf_done), 64'(0));
        check("reset_perf_stall", 64'(perf_stall), 64'(0));
        @(posedge clk);
        #1;

        // all-ones operands, every op back to back
        for (int op = 0; op < 4; op++) issue(2'(op), ones, ones, TW'(op + 1));
        drain();

        // MSB-only operands
        for (int op = 0; op < 4; op++) issue(2'(op), msb, msb, TW'(op + 8));
        drain();

        // stream under the 1,0,0,1 ready pattern
        ready_mode = 1;
        for (int i = 0; i < 10; i++) issue(2'($urandom_range(0, 3)), rnd_operand(), rnd_operand(), TW'(i));
        drain();

        // flush with a full, stalled pipe and a 4th op presented
        ready_mode = 3;
        idle(2);
        for (int i = 0; i < 3; i++) issue(2'(i), rnd_operand(), rnd_operand(), TW'(20 + i));
        in_valid = 1'b1;
        in_op    = 2'd3;
        in_a     = rnd_operand();
        in_b     = rnd_operand();
        in_tag   = TW'(23);
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        ready_mode = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("flush_out_valid", 64'(out_valid), 64'(0));
        end
        @(posedge clk);
        #1;
        issue(2'd1, rnd_operand(), rnd_operand(), TW'(24));
        drain();

        // reset with three ops in flight
        for (int i = 0; i < 3; i++) issue(2'(i + 1), rnd_operand(), rnd_operand(), TW'(25 + i));
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_inflight_valid", 64'(out_valid), 64'(0));
        check("rst_inflight_result", 64'(out_result), 64'(0));
`ifdef NIOS2_MUL_PERF_EN
        check("rst_perf_done", 64'(perf_done), 64'(0));
        check("rst_perf_stall", 64'(perf_stall), 64'(0));
`endif
        @(posedge clk);
        #1;
        idle(6);
        drain();

        // random traffic with random backpressure, gaps and rare flushes
        ready_mode = 2;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                in_valid = $urandom_range(0, 1) == 1;
                in_op    = 2'($urandom_range(0, 3));
                in_a     = rnd_operand();
                in_b     = rnd_operand();
                flush    = 1'b1;
                @(posedge clk);
                #1;
                flush    = 1'b0;
                in_valid = 1'b0;
            end
            if ($urandom_range(0, 3) == 0) idle(1);
            issue(2'($urandom_range(0, 3)), rnd_operand(), rnd_operand(), TW'($urandom_range(0, 31)));
        end
        drain();
        idle(2);

`ifdef NIOS2_MUL_PERF_EN
        check("perf_done_total", 64'(perf_done), 64'(done_m));
        check("perf_stall_total", 64'(perf_stall), 64'(stall_m));
`else
        check("perf_done_tied", 64'(perf_done), 64'(0));
        check("perf_stall_tied", 64'(perf_stall), 64'(0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
